// File: rtl/irq_priority_resolver_if.sv
// irq_priority_resolver_if: request/acknowledge bundle between CPU side and resolver
interface irq_priority_resolver_if #(parameter int N = 8) ();
  localparam int W = $clog2(N);
  logic [N-1:0] ir;
  logic [N-1:0] imr;
  logic         rotate_en;
  logic         inta;
  logic         eoi;
  logic         int_out;
  logic [W-1:0] vector_out;
  logic         vector_valid;
  logic         spurious;
  logic [N-1:0] irr;
  logic [N-1:0] isr;
  modport master (
    output ir, imr, rotate_en, inta, eoi,
    input  int_out, vector_out, vector_valid, spurious, irr, isr
  );
  modport slave (
    input  ir, imr, rotate_en, inta, eoi,
    output int_out, vector_out, vector_valid, spurious, irr, isr
  );
endinterface

// File: rtl/irq_priority_resolver.sv
// irq_priority_resolver: edge-latched N-channel interrupt resolver with masking,
// fixed/rotating priority and an INT/INTA/EOI handshake
module irq_priority_resolver #(
  parameter int N = 8
) (
  input logic                     clk,
  input logic                     rst,
  irq_priority_resolver_if.slave  bus_io
);
  localparam int W = $clog2(N);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t       state_q, state_d;
  logic [N-1:0] ir_q, irr_q, irr_d, isr_q, isr_d, elig;
  logic [W-1:0] lo_ptr_q, lo_ptr_d, ptr, idx, win, vec_q, vec_d;
  logic         found, int_q, valid_q, valid_d, spur_q, spur_d;
  // Scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    ptr   = bus_io.rotate_en ? lo_ptr_q : W'(N - 1);
    elig  = irr_q & ~bus_io.imr;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = ptr + W'(k);
      if (elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d  = state_q;
    irr_d    = irr_q;
    isr_d    = isr_q;
    vec_d    = vec_q;
    valid_d  = 1'b0;
    spur_d   = 1'b0;
    lo_ptr_d = lo_ptr_q;
    case (state_q)
      IDLE: state_d = |elig ? REQ : IDLE;
      REQ: begin
        if (bus_io.inta) begin
          state_d = found ? SERVICE : IDLE;
          vec_d   = found ? win : W'(N - 1);
          valid_d = 1'b1;
          spur_d  = !found;
          if (found) begin
            isr_d      = '0;
            isr_d[win] = 1'b1;
            irr_d[win] = 1'b0;
          end
        end else if (!(|elig)) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus_io.eoi) begin
          state_d  = IDLE;
          isr_d    = '0;
          lo_ptr_d = vec_q;
        end
      end
      default: state_d = IDLE;
    endcase
    lo_ptr_d = bus_io.rotate_en ? lo_ptr_d : W'(N - 1);
    irr_d    = irr_d | (bus_io.ir & ~ir_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      vec_q    <= '0;
      valid_q  <= 1'b0;
      spur_q   <= 1'b0;
      int_q    <= 1'b0;
      lo_ptr_q <= W'(N - 1);
    end else begin
      state_q  <= state_d;
      ir_q     <= bus_io.ir;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      vec_q    <= vec_d;
      valid_q  <= valid_d;
      spur_q   <= spur_d;
      int_q    <= (state_d == REQ);
      lo_ptr_q <= lo_ptr_d;
    end
  end
  assign bus_io.int_out      = int_q;
  assign bus_io.vector_out   = vec_q;
  assign bus_io.vector_valid = valid_q;
  assign bus_io.spurious     = spur_q;
  assign bus_io.irr          = irr_q;
  assign bus_io.isr          = isr_q;
endmodule

// File: tb/tb_irq_priority_resolver.sv
// tb_irq_priority_resolver: directed scenarios plus random traffic against a
// cycle-level behavioural model of the resolver
module tb_irq_priority_resolver;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  irq_priority_resolver_if #(.N(N))  b ();
  irq_priority_resolver_if #(.N(16)) b16 ();
  irq_priority_resolver #(.N(N))  dut   (.clk(clk), .rst(rst), .bus_io(b));
  irq_priority_resolver #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus_io(b16));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic pulse_inta();
    b.inta = 1'b1;
    cyc();
    b.inta = 1'b0;
  endtask
  task automatic pulse_eoi();
    b.eoi = 1'b1;
    cyc();
    b.eoi = 1'b0;
  endtask
  task automatic wait_int(input int max);
    int n = 0;
    while (b.int_out !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
    chk("wait_int", b.int_out, 1);
  endtask
  // Behavioural model: pending set, one optional serviced channel, request flag
  logic [N-1:0] m_irr = '0, m_prev = '0, m_edges, m_elig;
  int m_svc = -1, m_lo = N - 1, m_vec = 0, m_win, lo_eff;
  bit m_int = 0, m_valid = 0, m_spur = 0, m_busy = 0;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_irr = '0; m_prev = '0; m_svc = -1; m_lo = N - 1; m_vec = 0;
      m_int = 0; m_valid = 0; m_spur = 0; m_busy = 0;
    end else begin
      m_edges = b.ir & ~m_prev;
      m_prev  = b.ir;
      m_elig  = m_irr & ~b.imr;
      lo_eff  = b.rotate_en ? m_lo : N - 1;
      m_win   = -1;
      for (int k = 1; k <= N; k++)
        if (m_win < 0 && m_elig[(lo_eff + k) % N]) m_win = (lo_eff + k) % N;
      m_valid = 0;
      m_spur  = 0;
      if (m_busy) begin
        if (b.eoi) begin
          m_busy = 0;
          m_lo   = m_svc;
          m_svc  = -1;
        end
      end else if (m_int) begin
        if (b.inta) begin
          m_int   = 0;
          m_valid = 1;
          if (m_win >= 0) begin
            m_busy = 1;
            m_svc  = m_win;
            m_vec  = m_win;
            m_irr[m_win] = 1'b0;
          end else begin
            m_vec  = N - 1;
            m_spur = 1;
          end
        end else if (m_elig == 0) begin
          m_int = 0;
        end
      end else if (m_elig != 0) begin
        m_int = 1;
      end
      if (!b.rotate_en) m_lo = N - 1;
      m_irr = m_irr | m_edges;
    end
  end
  initial forever begin
    logic [N-1:0] exp_isr;
    @(posedge clk);
    #2;
    if (!rst) begin
      exp_isr = '0;
      if (m_busy) exp_isr[m_svc] = 1'b1;
      chk("m_int_out", b.int_out, m_int);
      chk("m_vector_out", b.vector_out, m_vec);
      chk("m_vector_valid", b.vector_valid, m_valid);
      chk("m_spurious", b.spurious, m_spur);
      chk("m_irr", b.irr, m_irr);
      chk("m_isr", b.isr, exp_isr);
      chk("m_lo_ptr", dut.lo_ptr_q, m_lo);
    end
  end
  initial begin
    {b.ir, b.imr, b.rotate_en, b.inta, b.eoi} = '0;
    {b16.ir, b16.imr, b16.rotate_en, b16.inta, b16.eoi} = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_int", b.int_out, 0);
    chk("rst_vec", b.vector_out, 0);
    chk("rst_valid", b.vector_valid, 0);
    chk("rst_spur", b.spurious, 0);
    chk("rst_irr", b.irr, 0);
    chk("rst_isr", b.isr, 0);
    chk("rst_lo", dut.lo_ptr_q, 7);
    // fixed priority, two simultaneous edges
    b.ir = 8'h24; cyc(); b.ir = '0;
    chk("fx_irr", b.irr, 8'h24);
    chk("fx_int0", b.int_out, 0);
    cyc();
    chk("fx_int1", b.int_out, 1);
    pulse_inta();
    chk("fx_vec2", b.vector_out, 2);
    chk("fx_isr", b.isr, 8'h04);
    chk("fx_irr2", b.irr, 8'h20);
    chk("fx_valid", b.vector_valid, 1);
    chk("fx_int_ack", b.int_out, 0);
    pulse_eoi();
    chk("fx_isr_eoi", b.isr, 0);
    chk("fx_valid_fall", b.vector_valid, 0);
    chk("fx_int_eoi", b.int_out, 0);
    cyc();
    chk("fx_int_again", b.int_out, 1);
    pulse_inta();
    chk("fx_vec5", b.vector_out, 5);
    pulse_eoi();
    // rotating priority
    b.rotate_en = 1'b1;
    b.ir = 8'h08; cyc(); b.ir = '0;
    wait_int(4);
    pulse_inta();
    chk("rot_vec3", b.vector_out, 3);
    pulse_eoi();
    chk("rot_lo3", dut.lo_ptr_q, 3);
    b.ir = 8'h42; cyc(); b.ir = '0;
    wait_int(4);
    pulse_inta();
    chk("rot_vec6", b.vector_out, 6);
    pulse_eoi();
    chk("rot_lo6", dut.lo_ptr_q, 6);
    wait_int(4);
    pulse_inta();
    chk("rot_vec1", b.vector_out, 1);
    pulse_eoi();
    b.rotate_en = 1'b0;
    cyc();
    chk("rot_lo_fixed", dut.lo_ptr_q, 7);
    // mask
    b.imr = 8'h10;
    b.ir = 8'h10; cyc(); b.ir = '0;
    cyc(); cyc();
    chk("msk_irr", b.irr, 8'h10);
    chk("msk_int", b.int_out, 0);
    b.imr = '0;
    cyc(); cyc();
    chk("msk_int_clr", b.int_out, 1);
    pulse_inta();
    chk("msk_vec4", b.vector_out, 4);
    pulse_eoi();
    // spurious acknowledge
    b.ir = 8'h80;
    wait_int(4);
    b.imr = 8'h80;
    pulse_inta();
    chk("sp_vec", b.vector_out, 7);
    chk("sp_spur", b.spurious, 1);
    chk("sp_valid", b.vector_valid, 1);
    chk("sp_isr", b.isr, 0);
    chk("sp_irr", b.irr, 8'h80);
    chk("sp_int", b.int_out, 0);
    cyc();
    chk("sp_valid_fall", b.vector_valid, 0);
    chk("sp_idle", b.int_out, 0);
    b.ir = '0;
    b.imr = '0;
    wait_int(4);
    pulse_inta();
    chk("sp_vec_real", b.vector_out, 7);
    chk("sp_spur_clr", b.spurious, 0);
    pulse_eoi();
    // handshake abuse
    pulse_inta();
    chk("ab_inta_idle_valid", b.vector_valid, 0);
    chk("ab_inta_idle_int", b.int_out, 0);
    b.ir = 8'h08; cyc(); b.ir = '0;
    wait_int(4);
    pulse_eoi();
    chk("ab_eoi_req_int", b.int_out, 1);
    chk("ab_eoi_req_isr", b.isr, 0);
    pulse_inta();
    chk("ab_vec3", b.vector_out, 3);
    chk("ab_isr3", b.isr, 8'h08);
    b.ir = 8'h01; cyc(); b.ir = '0;
    cyc();
    chk("ab_nest_irr", b.irr, 8'h01);
    chk("ab_nest_int", b.int_out, 0);
    b.inta = 1'b1; b.eoi = 1'b1; cyc(); b.inta = 1'b0; b.eoi = 1'b0;
    chk("ab_both_isr", b.isr, 0);
    chk("ab_both_valid", b.vector_valid, 0);
    wait_int(4);
    pulse_inta();
    chk("ab_vec0", b.vector_out, 0);
    chk("ab_valid_pre_rst", b.vector_valid, 1);
    // asynchronous reset in SERVICE with vector_valid high
    #1 rst = 1'b1;
    #1;
    chk("ar_int", b.int_out, 0);
    chk("ar_vec", b.vector_out, 0);
    chk("ar_valid", b.vector_valid, 0);
    chk("ar_isr", b.isr, 0);
    chk("ar_irr", b.irr, 0);
    chk("ar_lo", dut.lo_ptr_q, 7);
    b.ir = 8'h01;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("ar_edge_irr", b.irr, 8'h01);
    b.ir = '0;
    wait_int(4);
    pulse_inta();
    chk("ar_vec0", b.vector_out, 0);
    pulse_eoi();
    // sixteen channels
    b16.ir = 16'h4200; cyc(); b16.ir = '0;
    cyc();
    chk("n16_int", b16.int_out, 1);
    b16.inta = 1'b1; cyc(); b16.inta = 1'b0;
    chk("n16_vec9", b16.vector_out, 9);
    chk("n16_isr", b16.isr, 16'h0200);
    chk("n16_irr", b16.irr, 16'h4000);
    b16.eoi = 1'b1; cyc(); b16.eoi = 1'b0;
    cyc();
    chk("n16_int_again", b16.int_out, 1);
    b16.inta = 1'b1; cyc(); b16.inta = 1'b0;
    chk("n16_vec14", b16.vector_out, 14);
    // random traffic, model-checked every cycle
    repeat (3000) begin
      cyc();
      b.ir = b.ir ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(15) == 0) b.imr = N'($urandom) & N'($urandom);
      if ($urandom_range(31) == 0) b.rotate_en = ~b.rotate_en;
      b.inta = ($urandom_range(3) == 0);
      b.eoi  = ($urandom_range(3) == 0);
    end
    b.inta = 1'b0;
    b.eoi = 1'b0;
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
